ascon_permutation_core: RTL and testbench
=========================================

Name: ascon_permutation_core

Overview:
- Iterative, parametrised Ascon-p[r] permutation engine (NIST SP 800-232).
- Each pipeline step applies UNROLL rounds per clock. A round is constant addition, then the 5-bit S-box layer, then linear diffusion.
- The caller sets the round count per request (e.g. 12 for init/final, 8 or 6 for data processing).
- Sits between the mode controllers (AEAD/hash/XOF) and the state register. Uses a start/ready input handshake and a valid/ready output handshake.

Parameters:
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 3, 4, 6; elaboration error otherwise.
- MAX_ROUNDS, 12, largest accepted round count; fixed to 12 by the standard.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous reset, active-low.
- start_i  input  1  request; accepted when start_i & ready_o.
- rounds_i  input  4  rounds r for this request; legal range 1..12.
- state_i  input  320 (ascon_state_t)  input state; index 0 = S0, index 4 = S4.
- abort_i  input  1  synchronous abort; returns the core to IDLE.
- ready_o  output  1  core can accept a request this cycle.
- busy_o  output  1  high in RUN.
- out_valid_o  output  1  state_o holds a completed permutation.
- out_ready_i  input  1  consumer takes the result when out_valid_o & out_ready_i.
- state_o  output  320 (ascon_state_t)  result state.
- err_o  output  1  one-cycle pulse when a request with an illegal rounds_i is rejected.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE; state register and state_o clear to 0.
  - Round counter clears to 0; ready_o=1; busy_o=0; out_valid_o=0; err_o=0.
- FSM states: IDLE, RUN, DONE.
- ready_o = IDLE | (DONE & out_ready_i).
- Accept edge, legal request:
  - Latch state_i.
  - Set round index i = 12 - r.
  - Set end index = 12.
  - Go to RUN.
- Illegal rounds_i (0 or >12) with start_i & ready_o:
  - Not accepted; state register unchanged.
  - err_o=1 for the next cycle only.
  - FSM goes to or stays in IDLE. When this happens from DONE with out_ready_i, the result is still consumed.
- Round stage k (0..UNROLL-1) is active iff i+k < 12. Each active stage does the following, in order:
  - Constant addition: S2[7:0] ^= {4'hF - (i+k), i+k}. Upper bits of S2 are unchanged.
  - S-box: the Ascon 5-bit S-box is applied bitwise across S0..S4 (S0 is the MSB of each column).
  - Linear diffusion, with rotate-right amounts:
    - S0: 19, 28
    - S1: 61, 39
    - S2: 1, 6
    - S3: 10, 17
    - S4: 7, 41
  - An inactive stage passes its input through unchanged. This lets the final clock execute fewer than UNROLL rounds.
- RUN:
  - Each edge registers the chained output of all stages and sets i += UNROLL (saturating at 12).
  - When the updated i reaches 12, go to DONE.
- Latency: out_valid_o rises exactly ceil(r/UNROLL) edges after the accept edge.
  - Example: UNROLL=1, r=12 gives 12 edges.
  - Example: UNROLL=4, r=6 gives 2 edges (4 rounds, then 2).
- DONE:
  - out_valid_o=1; state_o holds the result, stable until consumed.
  - With out_ready_i & ~start_i: go to IDLE.
  - With out_ready_i & start_i (legal): back-to-back accept into RUN on the same edge; no idle bubble.
  - With ~out_ready_i: hold indefinitely; start_i is ignored.
- state_o is driven from the state register at all times. Its value is meaningful only when out_valid_o=1.
- abort_i:
  - Top priority over start and over completion.
  - Next edge goes to IDLE and clears out_valid_o; the state register is left as is.
  - A start in the same cycle is not accepted; ready_o is forced to 0 while abort_i=1.
- Mid-operation reset: asynchronous return to the reset values listed above; no partial result is presented.
- start_i in RUN is ignored; no queueing.

Test Plan:
- Latency sweep, UNROLL=1, random state: start with r=12, then r=8, then r=6 → out_valid_o after 12, 8 and 6 edges respectively; state_o matches the golden Ascon-p model; busy_o=1 exactly during those edges.
- UNROLL=4, r=6, then r=12 → results after 2 and 3 edges; state_o equals the UNROLL=1 result for the same input (checks partial final clock).
- Illegal rounds: start with rounds_i=0, then rounds_i=13 → err_o pulses one cycle each; out_valid_o never rises; ready_o stays 1.
- Backpressure and back-to-back:
  - Hold out_ready_i=0 for 5 cycles after DONE → state_o and out_valid_o stable.
  - Then assert out_ready_i with start_i=1, r=6 → next result exactly 6 edges later (UNROLL=1).
- Abort at the 3rd RUN edge of r=12 → IDLE next cycle, out_valid_o=0, ready_o=1; a new request runs to a correct result.
- Deassert rst_ni asynchronously mid-RUN → outputs at reset values before the next clock edge; out_valid_o=0 after release.

Source files
------------

// File: rtl/ascon_permutation_core.sv
// ---------------------------------------------------------------------------
// ascon_permutation_core
//   Iterative Ascon-p[r] permutation engine. UNROLL rounds are evaluated per
//   clock by a chain of round stages; the final clock of a request may run
//   fewer than UNROLL rounds because a stage whose round index has reached
//   MAX_ROUNDS passes its input through unchanged.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_ni       asynchronous reset, active low
//     start_i      request, taken when start_i & ready_o
//     rounds_i     round count r for the request (legal 1..12)
//     state_i      input state, word 0 = S0 ... word 4 = S4
//     abort_i      synchronous abort back to IDLE (highest priority)
//     ready_o      a request can be taken this cycle
//     busy_o       permutation in progress
//     out_valid_o  state_o holds a finished permutation
//     out_ready_i  consumer takes the result on out_valid_o & out_ready_i
//     state_o      result state (always the state register)
//     err_o        one-cycle pulse after an illegal rounds_i was rejected
// ---------------------------------------------------------------------------

// One Ascon round: constant addition, S-box layer, linear diffusion.
// idx_i is the absolute round index; at 12 or above the stage is a wire.
module ascon_round_stage (
    input  logic [4:0][63:0] s_i,
    input  logic [4:0]       idx_i,
    output logic [4:0][63:0] s_o
);
    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [7:0]  rc;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] l0, l1, l2, l3, l4;

    always_comb begin
        rc = {4'hF - idx_i[3:0], idx_i[3:0]};

        x0 = s_i[0];
        x1 = s_i[1];
        x2 = s_i[2] ^ {56'd0, rc};
        x3 = s_i[3];
        x4 = s_i[4];

        // Bit-sliced form of the 5-bit S-box (S0 is the column MSB).
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        l0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        l1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        l2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        l3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        l4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);

        s_o = (idx_i < 5'd12) ? {l4, l3, l2, l1, l0} : s_i;
    end
endmodule

module ascon_permutation_core #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       rounds_i,
    input  logic [4:0][63:0] state_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0][63:0] state_o,
    output logic             err_o
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 4 && UNROLL != 6) begin : g_bad_unroll
        $error("ascon_permutation_core: UNROLL must be 1, 2, 3, 4 or 6");
    end

    localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [4:0][63:0] state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             err_q, err_d;

    // Round stage chain; stage k works on absolute round index rnd_q + k.
    logic [UNROLL:0][4:0][63:0] chain;
    assign chain[0] = state_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        ascon_round_stage u_stage (
            .s_i   (chain[k]),
            .idx_i ({1'b0, rnd_q} + 5'(k)),
            .s_o   (chain[k+1])
        );
    end

    logic [4:0] rnd_sum;
    logic [3:0] rnd_nx;
    logic       legal;

    always_comb begin
        rnd_sum = {1'b0, rnd_q} + 5'(UNROLL);
        rnd_nx  = (rnd_sum >= {1'b0, LAST_IDX}) ? LAST_IDX : rnd_sum[3:0];
        legal   = (rounds_i != 4'd0) && (rounds_i <= LAST_IDX);
        ready_o = ~abort_i & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready_i));

        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        err_d   = 1'b0;

        if (abort_i) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                RUN: begin
                    state_d = chain[UNROLL];
                    rnd_d   = rnd_nx;
                    if (rnd_nx == LAST_IDX) fsm_d = DONE;
                end
                DONE: begin
                    if (out_ready_i) fsm_d = IDLE;
                end
                default: ;
            endcase

            // ready_o already covers "IDLE, or DONE being consumed".
            if (start_i && ready_o) begin
                if (legal) begin
                    state_d = state_i;
                    rnd_d   = LAST_IDX - rounds_i;
                    fsm_d   = RUN;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (fsm_q == RUN);
    assign out_valid_o = (fsm_q == DONE);
    assign state_o     = state_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_ascon_permutation_core.sv
// ---------------------------------------------------------------------------
// tb_ascon_permutation_core
//   Two cores (UNROLL=1 and UNROLL=4) driven from shared data inputs with
//   separate start strobes. Results are compared with a column-wise table
//   lookup model of Ascon-p[r].
// ---------------------------------------------------------------------------
module tb_ascon_permutation_core;
    typedef logic [4:0][63:0] st_t;

    typedef struct {
        int         sel;   // 0: UNROLL=1 core, 1: UNROLL=4 core
        logic [3:0] r;
        st_t        st;
        st_t        exp;
    } vec_t;

    localparam int SBOX [32] = '{
        'h04, 'h0b, 'h1f, 'h14, 'h1a, 'h15, 'h09, 'h02,
        'h1b, 'h05, 'h08, 'h12, 'h1d, 'h03, 'h06, 'h1c,
        'h1e, 'h13, 'h07, 'h0e, 'h00, 'h0d, 'h11, 'h18,
        'h10, 'h0c, 'h01, 'h19, 'h16, 'h0a, 'h0f, 'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start4 = 1'b0;
    logic [3:0] rounds = 4'd0;
    st_t        state_in = '0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;

    logic rdy1, busy1, ov1, err1;
    logic rdy4, busy4, ov4, err4;
    st_t  so1, so4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_permutation_core #(.UNROLL(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .rounds_i(rounds),
        .state_i(state_in), .abort_i(abort), .ready_o(rdy1), .busy_o(busy1),
        .out_valid_o(ov1), .out_ready_i(out_ready), .state_o(so1), .err_o(err1));

    ascon_permutation_core #(.UNROLL(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .rounds_i(rounds),
        .state_i(state_in), .abort_i(abort), .ready_o(rdy4), .busy_o(busy4),
        .out_valid_o(ov4), .out_ready_i(out_ready), .state_o(so4), .err_o(err4));

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference permutation: rounds 12-r..11, S-box by table per column.
    function automatic st_t model_perm(input st_t s, input int r);
        st_t x, y;
        int  idx, v;
        x = s;
        for (int j = 12 - r; j < 12; j++) begin
            x[2][7:0] = x[2][7:0] ^ 8'((15 - j) * 16 + j);
            for (int b = 0; b < 64; b++) begin
                idx = 16 * int'(x[0][b]) + 8 * int'(x[1][b]) + 4 * int'(x[2][b])
                    + 2 * int'(x[3][b]) + int'(x[4][b]);
                v = SBOX[idx];
                for (int w = 0; w < 5; w++) y[w][b] = v[4 - w];
            end
            for (int w = 0; w < 5; w++)
                x[w] = y[w] ^ rotr(y[w], ROT_A[w]) ^ rotr(y[w], ROT_B[w]);
        end
        return x;
    endfunction

    function automatic st_t rand_st();
        st_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
        return s;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Issue one legal request (caller is at a negedge) and follow it to DONE.
    task automatic run_req(input int sel, input logic [3:0] r, input st_t st,
                           input st_t exp, input string nm);
        int n, lat, u;
        u   = (sel != 0) ? 4 : 1;
        lat = (int'(r) + u - 1) / u;
        rounds   = r;
        state_in = st;
        if (sel != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if ((sel != 0) ? ov4 : ov1) break;
            chk({nm, "_busy"}, (sel != 0) ? busy4 : busy1, 1'b1);
            if (n >= 40) begin
                chk({nm, "_timeout"}, 1'b0, 1'b1);
                break;
            end
            @(posedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_state"}, (sel != 0) ? so4 : so1, exp);
        chk({nm, "_busy_done"}, (sel != 0) ? busy4 : busy1, 1'b0);
    endtask

    vec_t tbl [10];
    st_t  sa, sb, sc, hold;

    initial begin
        sa = rand_st();
        sb = rand_st();
        sc = rand_st();
        tbl[0] = '{0, 4'd12, sa, '0};
        tbl[1] = '{0, 4'd8,  sb, '0};
        tbl[2] = '{0, 4'd6,  sc, '0};
        tbl[3] = '{1, 4'd6,  sc, '0};
        tbl[4] = '{1, 4'd12, sa, '0};
        tbl[5] = '{0, 4'd1,  sb, '0};
        tbl[6] = '{1, 4'd1,  sa, '0};
        tbl[7] = '{1, 4'd11, sb, '0};
        tbl[8] = '{1, 4'd3,  sc, '0};
        tbl[9] = '{0, 4'd12, '0, '0};
        foreach (tbl[i]) tbl[i].exp = model_perm(tbl[i].st, int'(tbl[i].r));

        // Reset values
        #3;
        chk("rst_state", so1, '0);
        chk("rst_ready", {rdy1, rdy4}, 2'b11);
        chk("rst_busy", {busy1, busy4}, 2'b00);
        chk("rst_valid", {ov1, ov4}, 2'b00);
        chk("rst_err", {err1, err4}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: latency sweep on both unroll factors
        for (int i = 0; i < 10; i++)
            run_req(tbl[i].sel, tbl[i].r, tbl[i].st, tbl[i].exp, $sformatf("vec%0d", i));

        // Randomised requests
        for (int i = 0; i < 12; i++) begin
            int   sel;
            logic [3:0] r;
            st_t  s;
            sel = int'($urandom_range(1, 0));
            r   = 4'($urandom_range(12, 1));
            s   = rand_st();
            run_req(sel, r, s, model_perm(s, int'(r)), $sformatf("rnd%0d", i));
        end

        // Illegal round counts
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rounds = (k == 0) ? 4'd0 : 4'd13;
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            chk($sformatf("ill%0d_err", k), err1, 1'b1);
            chk($sformatf("ill%0d_ready", k), rdy1, 1'b1);
            chk($sformatf("ill%0d_valid", k), ov1, 1'b0);
            @(negedge clk);
            chk($sformatf("ill%0d_err_clr", k), err1, 1'b0);
            chk($sformatf("ill%0d_valid2", k), {ov1, busy1}, 2'b00);
        end

        // Backpressure, then back-to-back accept on the consuming edge
        out_ready = 1'b0;
        sa = rand_st();
        run_req(0, 4'd8, sa, model_perm(sa, 8), "bp_first");
        hold = so1;
        rounds   = 4'd5;
        state_in = rand_st();
        start1   = 1'b1;   // must be ignored while the result is held
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", ov1, 1'b1);
            chk("bp_state", so1, hold);
            chk("bp_ready", rdy1, 1'b0);
        end
        start1 = 1'b0;
        out_ready = 1'b1;
        sb = rand_st();
        run_req(0, 4'd6, sb, model_perm(sb, 6), "b2b");

        // Abort on the third RUN edge
        @(negedge clk);
        @(negedge clk);
        sc = rand_st();
        rounds   = 4'd12;
        state_in = sc;
        start1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_ready_low", rdy1, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", ov1, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_ready", rdy1, 1'b1);
        sa = rand_st();
        run_req(0, 4'd12, sa, model_perm(sa, 12), "after_abort");

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        rounds   = 4'd12;
        state_in = rand_st();
        start1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", so1, '0);
        chk("arst_busy", busy1, 1'b0);
        chk("arst_valid", ov1, 1'b0);
        chk("arst_ready", rdy1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_valid_rel", ov1, 1'b0);
        chk("arst_ready_rel", rdy1, 1'b1);
        sb = rand_st();
        run_req(1, 4'd8, sb, model_perm(sb, 8), "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
